// File: rtl/oserdes_link_pkg.sv
// -----------------------------------------------------------------------------
// oserdes_link_pkg
// Shared definitions for the 8:1 transmit serializer scheduler.
//   link_state_e : link FSM states (settle, training, idle, in-packet data)
//   Def*Word     : default control words placed on the serializer input
//   id_width()   : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package oserdes_link_pkg;

    typedef enum logic [1:0] {
        StSettle,
        StTrain,
        StIdle,
        StData
    } link_state_e;

    localparam logic [7:0] DefTrainWord = 8'h0F;
    localparam logic [7:0] DefIdleWord  = 8'hBC;
    localparam logic [7:0] DefSofWord   = 8'hFB;
    localparam logic [7:0] DefFillWord  = 8'h7C;
    localparam logic [7:0] SettleWord   = 8'h00;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among NUM_REQ requesters. The search starts at
// `pointer` and moves upward with wrap-around; the first valid requester wins.
//   req_valid : per-requester request
//   pointer   : highest-priority requester index for this decision
//   winner    : index of the chosen requester (0 when none is valid)
//   any_valid : at least one requester is valid
// -----------------------------------------------------------------------------
module rr_arbiter
    import oserdes_link_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IdW-1:0]     pointer,
    output logic [IdW-1:0]     winner,
    output logic               any_valid
);

    localparam int unsigned SumW = IdW + 1;
    localparam logic [IdW:0] NumReqW = NUM_REQ[IdW:0];

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;

    // Rotate so that bit 0 of `rotated` is the requester at `pointer`.
    assign doubled = {req_valid, req_valid};
    assign rotated = NUM_REQ'(doubled >> pointer);

    always_comb begin
        logic [IdW:0] sum;
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && rotated[k]) begin
                any_valid = 1'b1;
                // Map the rotated position back to an absolute index.
                sum = {1'b0, pointer} + SumW'(k);
                if (sum >= NumReqW) begin
                    sum = sum - NumReqW;
                end
                winner = sum[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/oserdes_tx_scheduler.sv
// -----------------------------------------------------------------------------
// oserdes_tx_scheduler
// Word-rate controller in front of the 8:1 transmit serializer. After reset the
// link is held at 0x00 for SETTLE_CYCLES words, then TRAIN_WORDS training words
// are sent and link_up rises with the first idle word. Afterwards requester
// packets are framed (SOF + payload) and interleaved round-robin, with idle
// words between packets and fill words whenever the owner stalls mid-packet.
//
// Ports:
//   clk_div_in           : word-rate clock shared with the serializer
//   io_reset             : asynchronous active-high reset
//   req_valid/data/last  : per-requester stream, requester i at data[8i+7:8i]
//   req_ready            : per-requester accept (only the packet owner in DATA)
//   retrain              : pulse; training is rerun at the next idle point
//   data_out_from_device : registered parallel word to the serializer
//   link_up              : high once training has completed
//   active_id            : current or most recently granted requester
// -----------------------------------------------------------------------------
module oserdes_tx_scheduler
    import oserdes_link_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TRAIN_WORDS   = 16,
    parameter logic [7:0]  TRAIN_WORD    = DefTrainWord,
    parameter logic [7:0]  IDLE_WORD     = DefIdleWord,
    parameter logic [7:0]  SOF_WORD      = DefSofWord,
    parameter logic [7:0]  FILL_WORD     = DefFillWord,
    localparam int unsigned IdW = id_width(NUM_REQ)
) (
    input  logic                 clk_div_in,
    input  logic                 io_reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 retrain,
    output logic [7:0]           data_out_from_device,
    output logic                 link_up,
    output logic [IdW-1:0]       active_id
);

    localparam int unsigned CntW = 16;
    localparam int unsigned SumW = IdW + 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TrainLast  = CntW'(TRAIN_WORDS - 1);
    localparam logic [IdW:0]    NumReqW    = NUM_REQ[IdW:0];

    link_state_e     state_q, state_d;
    logic [7:0]      word_q, word_d;
    logic            link_q, link_d;
    logic [IdW-1:0]  aid_q, aid_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;

    logic [IdW-1:0]  winner;
    logic            any_valid;
    logic [IdW-1:0]  next_ptr;
    logic [IdW:0]    ptr_sum;
    logic [7:0]      data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[8*g +: 8];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .pointer   (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Priority moves to the requester just after the winner.
    always_comb begin
        ptr_sum = {1'b0, winner} + SumW'(1);
        if (ptr_sum == NumReqW) begin
            ptr_sum = '0;
        end
    end
    assign next_ptr = ptr_sum[IdW-1:0];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        link_d  = link_q;
        aid_d   = aid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        // A retrain request is remembered until the link can act on it.
        pend_d  = pend_q | retrain;

        unique case (state_q)
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StTrain;
                    word_d  = TRAIN_WORD;
                    cnt_d   = '0;
                end else begin
                    word_d  = SettleWord;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StTrain: begin
                if (cnt_q == TrainLast) begin
                    state_d = StIdle;
                    word_d  = IDLE_WORD;
                    link_d  = 1'b1;
                    cnt_d   = '0;
                    // Retrains seen during bring-up/training are already served.
                    pend_d  = 1'b0;
                end else begin
                    word_d  = TRAIN_WORD;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (pend_q) begin
                    state_d = StTrain;
                    word_d  = TRAIN_WORD;
                    link_d  = 1'b0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (any_valid) begin
                    state_d = StData;
                    word_d  = SOF_WORD;
                    aid_d   = winner;
                    ptr_d   = next_ptr;
                end else begin
                    word_d  = IDLE_WORD;
                end
            end
            StData: begin
                if (req_valid[aid_q]) begin
                    word_d = data_arr[aid_q];
                    if (req_last[aid_q]) begin
                        state_d = StIdle;
                    end
                end else begin
                    // Owner stalled: keep the packet open with filler.
                    word_d = FILL_WORD;
                end
            end
            default: begin
                state_d = StSettle;
            end
        endcase
    end

    // Only the packet owner is accepted, and only while a packet is open.
    always_comb begin
        req_ready = '0;
        if (state_q == StData) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (aid_q == IdW'(i));
            end
        end
    end

    always_ff @(posedge clk_div_in or posedge io_reset) begin
        if (io_reset) begin
            state_q <= StSettle;
            word_q  <= SettleWord;
            link_q  <= 1'b0;
            aid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            link_q  <= link_d;
            aid_q   <= aid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign data_out_from_device = word_q;
    assign link_up              = link_q;
    assign active_id            = aid_q;

endmodule

// File: tb/tb_oserdes_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_oserdes_tx_scheduler
// Self-checking bench: an edge-count based model of the link timeline and the
// packet framing rules is compared with the DUT every cycle, and directed
// scenarios are pinned with literal word sequences from a captured trace.
// -----------------------------------------------------------------------------
module tb_oserdes_tx_scheduler;

    localparam int S = 4;
    localparam int T = 16;
    localparam logic [7:0] WTrain = 8'h0F;
    localparam logic [7:0] WIdle  = 8'hBC;
    localparam logic [7:0] WSof   = 8'hFB;
    localparam logic [7:0] WFill  = 8'h7C;

    logic        clk_div_in = 1'b0;
    logic        io_reset   = 1'b0;
    logic [1:0]  req_valid  = '0;
    logic [15:0] req_data   = '0;
    logic [1:0]  req_last   = '0;
    logic [1:0]  req_ready;
    logic        retrain    = 1'b0;
    logic [7:0]  data_out_from_device;
    logic        link_up;
    logic        active_id;

    oserdes_tx_scheduler #(
        .NUM_REQ       (2),
        .SETTLE_CYCLES (S),
        .TRAIN_WORDS   (T),
        .TRAIN_WORD    (WTrain),
        .IDLE_WORD     (WIdle),
        .SOF_WORD      (WSof),
        .FILL_WORD     (WFill)
    ) dut (
        .clk_div_in           (clk_div_in),
        .io_reset             (io_reset),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .retrain              (retrain),
        .data_out_from_device (data_out_from_device),
        .link_up              (link_up),
        .active_id            (active_id)
    );

    initial forever #5 clk_div_in = ~clk_div_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // e counts clock edges since reset release; the word after edge e is a
    // settle word or training word while e <= train_until.
    int         e           = 0;
    int         train_until = S + T - 1;
    int         owner       = -1;
    int         m_aid       = 0;
    int         rr_ptr      = 0;
    bit         pending     = 0;
    logic [7:0] m_word      = 8'h00;
    logic       m_link      = 1'b0;
    logic [1:0] m_ready     = 2'b00;

    always @(posedge clk_div_in or posedge io_reset) begin
        bit absorbed;
        if (io_reset) begin
            e = 0; train_until = S + T - 1; owner = -1; m_aid = 0; rr_ptr = 0;
            pending = 0; m_word = 8'h00; m_link = 1'b0; m_ready = 2'b00;
        end else begin
            e++;
            absorbed = (e <= train_until + 1);
            if (e <= train_until) begin
                m_word = (e > train_until - T) ? WTrain : 8'h00;
            end else if (e == train_until + 1) begin
                m_word = WIdle;
            end else if (owner < 0) begin
                if (pending) begin
                    train_until = e + T - 1;
                    m_word = WTrain;
                    pending = 0;
                    absorbed = 1;
                end else begin
                    m_word = WIdle;
                    for (int k = 0; k < 2; k++) begin
                        int idx;
                        idx = (rr_ptr + k) % 2;
                        if (owner < 0 && req_valid[idx]) begin
                            owner = idx; m_aid = idx; rr_ptr = (idx + 1) % 2;
                            m_word = WSof;
                        end
                    end
                end
            end else begin
                if (req_valid[owner]) begin
                    m_word = req_data[owner*8 +: 8];
                    if (req_last[owner]) owner = -1;
                end else begin
                    m_word = WFill;
                end
            end
            if (retrain && !absorbed) pending = 1;
            m_link  = (e > train_until);
            m_ready = (owner >= 0) ? 2'(1 << owner) : 2'b00;
        end
    end

    // ---------------- trace + per-cycle compare ----------------
    logic [7:0] tr_w [$];
    logic       tr_l [$];
    logic [1:0] tr_r [$];
    logic       tr_a [$];

    always @(posedge clk_div_in) begin
        #2;
        if (!io_reset) begin
            tr_w.push_back(data_out_from_device);
            tr_l.push_back(link_up);
            tr_r.push_back(req_ready);
            tr_a.push_back(active_id);
            chk("cyc_word", 32'(data_out_from_device), 32'(m_word));
            chk("cyc_link_up", 32'(link_up), 32'(m_link));
            chk("cyc_req_ready", 32'(req_ready), 32'(m_ready));
            chk("cyc_active_id", 32'(active_id), 32'(m_aid));
        end
    end

    function automatic logic [7:0] tw(input int i);
        if (i < 0 || i >= tr_w.size()) return 8'hxx;
        return tr_w[i];
    endfunction
    function automatic logic tl(input int i);
        if (i < 0 || i >= tr_l.size()) return 1'bx;
        return tr_l[i];
    endfunction
    function automatic logic ta(input int i);
        if (i < 0 || i >= tr_a.size()) return 1'bx;
        return tr_a[i];
    endfunction
    function automatic int find_word(input int from, input logic [7:0] w);
        for (int i = from; i < tr_w.size(); i++) if (tr_w[i] === w) return i;
        return -1;
    endfunction

    // ---------------- requester drivers ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [7:0] gap;
    } word_t;

    word_t mem [2][64];
    int    head [2]     = '{0, 0};
    int    tail [2]     = '{0, 0};
    int    gap_left [2] = '{0, 0};
    bit    fresh [2]    = '{1, 1};
    bit    hs [2]       = '{0, 0};

    always @(negedge clk_div_in) begin
        for (int i = 0; i < 2; i++) begin
            if (io_reset) begin
                head[i] = tail[i]; fresh[i] = 1; hs[i] = 0;
                req_valid[i] = 1'b0; req_last[i] = 1'b0;
            end else begin
                if (hs[i]) begin head[i]++; fresh[i] = 1; end
                if (head[i] != tail[i]) begin
                    if (fresh[i]) begin
                        gap_left[i] = int'(mem[i][head[i] % 64].gap);
                        fresh[i] = 0;
                    end
                    if (gap_left[i] > 0) begin
                        gap_left[i]--;
                        req_valid[i] = 1'b0; req_last[i] = 1'b0;
                    end else begin
                        req_valid[i] = 1'b1;
                        req_data[i*8 +: 8] = mem[i][head[i] % 64].d;
                        req_last[i] = mem[i][head[i] % 64].last;
                    end
                end else begin
                    req_valid[i] = 1'b0; req_last[i] = 1'b0;
                end
                hs[i] = req_valid[i] & req_ready[i];
            end
        end
    end

    task automatic push(input int r, input logic [7:0] wd, input logic wl, input int wg);
        mem[r][tail[r] % 64] = '{d: wd, last: wl, gap: 8'(wg)};
        tail[r]++;
    endtask

    task automatic wait_link(input int bound, input string name);
        int k = 0;
        while (link_up !== 1'b1 && k < bound) begin
            @(posedge clk_div_in); #3; k++;
        end
        n_cmp++;
        if (link_up !== 1'b1) begin
            n_err++;
            $display("FAIL %s: link_up got %b after %0d cycles, expected 1", name, link_up, bound);
        end
    endtask

    task automatic wait_ready(input int r, input int bound, input string name);
        int k = 0;
        while (req_ready[r] !== 1'b1 && k < bound) begin
            @(posedge clk_div_in); #3; k++;
        end
        n_cmp++;
        if (req_ready[r] !== 1'b1) begin
            n_err++;
            $display("FAIL %s: req_ready got %b after %0d cycles, expected 1", name, req_ready, bound);
        end
    endtask

    // Bring-up: after edges 1..3 words are 0x00, edges 4..19 training, edge 20 idle.
    task automatic check_boot(input int base, input string name);
        chk({name, "_settle_last"}, 32'(tw(base + 2)), 32'h00);
        chk({name, "_train_first"}, 32'(tw(base + 3)), 32'h0F);
        chk({name, "_train_last"}, 32'(tw(base + 18)), 32'h0F);
        chk({name, "_first_idle"}, 32'(tw(base + 19)), 32'hBC);
        chk({name, "_link_low_in_train"}, 32'(tl(base + 18)), 32'h0);
        chk({name, "_link_with_idle"}, 32'(tl(base + 19)), 32'h1);
    endtask

    function automatic int count_ready(input int from, input int bit_idx);
        int c = 0;
        for (int i = from; i < tr_r.size(); i++) if (tr_r[i][bit_idx] === 1'b1) c++;
        return c;
    endfunction

    task automatic sync_push();
        @(posedge clk_div_in); #4;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int mark;
        int i;

        #1 io_reset = 1'b1;
        #1;
        chk("reset_word", 32'(data_out_from_device), 32'h00);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_link", 32'(link_up), 32'h0);
        chk("reset_active_id", 32'(active_id), 32'h0);
        repeat (3) @(negedge clk_div_in);
        io_reset = 1'b0;
        mark = tr_w.size();
        wait_link(40, "boot_link");
        repeat (3) @(posedge clk_div_in);
        check_boot(mark, "boot");

        // Three-word packet from requester 0.
        sync_push();
        mark = tr_w.size();
        push(0, 8'h11, 1'b0, 0); push(0, 8'h22, 1'b0, 0); push(0, 8'h33, 1'b1, 0);
        repeat (12) @(posedge clk_div_in);
        #4;
        i = find_word(mark, WSof);
        chk("p0_before_sof", 32'(tw(i - 1)), 32'hBC);
        chk("p0_sof", 32'(tw(i)), 32'hFB);
        chk("p0_w0", 32'(tw(i + 1)), 32'h11);
        chk("p0_w1", 32'(tw(i + 2)), 32'h22);
        chk("p0_w2", 32'(tw(i + 3)), 32'h33);
        chk("p0_after", 32'(tw(i + 4)), 32'hBC);
        chk("p0_active_id", 32'(ta(i)), 32'h0);
        chk("p0_ready0_cycles", 32'(count_ready(mark, 0)), 32'd3);
        chk("p0_ready1_cycles", 32'(count_ready(mark, 1)), 32'd0);

        // Requester 1 stalls for two cycles mid-packet; pointer returns to 0.
        sync_push();
        mark = tr_w.size();
        push(1, 8'hA1, 1'b0, 0); push(1, 8'hA2, 1'b1, 2);
        repeat (12) @(posedge clk_div_in);
        #4;
        i = find_word(mark, WSof);
        chk("gap_sof", 32'(tw(i)), 32'hFB);
        chk("gap_w0", 32'(tw(i + 1)), 32'hA1);
        chk("gap_fill0", 32'(tw(i + 2)), 32'h7C);
        chk("gap_fill1", 32'(tw(i + 3)), 32'h7C);
        chk("gap_w1", 32'(tw(i + 4)), 32'hA2);
        chk("gap_after", 32'(tw(i + 5)), 32'hBC);
        chk("gap_active_id", 32'(ta(i)), 32'h1);

        // Contention with pointer at 0: requester 0 first, then requester 1.
        sync_push();
        mark = tr_w.size();
        push(0, 8'h41, 1'b0, 0); push(0, 8'h42, 1'b1, 0);
        push(1, 8'h51, 1'b0, 0); push(1, 8'h52, 1'b1, 0);
        repeat (14) @(posedge clk_div_in);
        #4;
        i = find_word(mark, WSof);
        chk("rr1_sof0", 32'(tw(i)), 32'hFB);
        chk("rr1_id0", 32'(ta(i)), 32'h0);
        chk("rr1_w0", 32'(tw(i + 1)), 32'h41);
        chk("rr1_w1", 32'(tw(i + 2)), 32'h42);
        chk("rr1_sof1", 32'(tw(i + 3)), 32'hFB);
        chk("rr1_id1", 32'(ta(i + 3)), 32'h1);
        chk("rr1_w2", 32'(tw(i + 4)), 32'h51);
        chk("rr1_w3", 32'(tw(i + 5)), 32'h52);
        chk("rr1_after", 32'(tw(i + 6)), 32'hBC);

        // Second contention, pointer back at 0: requester 0 wins again.
        sync_push();
        mark = tr_w.size();
        push(0, 8'h61, 1'b0, 0); push(0, 8'h62, 1'b1, 0);
        push(1, 8'h71, 1'b0, 0); push(1, 8'h72, 1'b1, 0);
        repeat (14) @(posedge clk_div_in);
        #4;
        i = find_word(mark, WSof);
        chk("rr2_id0", 32'(ta(i)), 32'h0);
        chk("rr2_w0", 32'(tw(i + 1)), 32'h61);
        chk("rr2_id1", 32'(ta(i + 3)), 32'h1);

        // Retrain pulsed mid-packet: packet completes, then full training.
        sync_push();
        mark = tr_w.size();
        push(0, 8'hC1, 1'b0, 0); push(0, 8'hC2, 1'b0, 0);
        push(0, 8'hC3, 1'b0, 0); push(0, 8'hC4, 1'b1, 0);
        wait_ready(0, 10, "rt_grant");
        @(negedge clk_div_in); retrain = 1'b1;
        @(negedge clk_div_in); retrain = 1'b0;
        repeat (30) @(posedge clk_div_in);
        #4;
        i = find_word(mark, WSof);
        chk("rt_w0", 32'(tw(i + 1)), 32'hC1);
        chk("rt_w3", 32'(tw(i + 4)), 32'hC4);
        chk("rt_link_in_pkt", 32'(tl(i + 4)), 32'h1);
        chk("rt_train_first", 32'(tw(i + 5)), 32'h0F);
        chk("rt_link_low", 32'(tl(i + 5)), 32'h0);
        chk("rt_train_last", 32'(tw(i + 20)), 32'h0F);
        chk("rt_link_low_end", 32'(tl(i + 20)), 32'h0);
        chk("rt_idle", 32'(tw(i + 21)), 32'hBC);
        chk("rt_link_up", 32'(tl(i + 21)), 32'h1);

        // Reset in the middle of a packet from requester 1.
        sync_push();
        push(1, 8'hD1, 1'b0, 0); push(1, 8'hD2, 1'b0, 0);
        push(1, 8'hD3, 1'b0, 3); push(1, 8'hD4, 1'b1, 0);
        wait_ready(1, 10, "rst_grant");
        repeat (2) @(posedge clk_div_in);
        #3 io_reset = 1'b1;
        #1;
        chk("mid_rst_word", 32'(data_out_from_device), 32'h00);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_link", 32'(link_up), 32'h0);
        chk("mid_rst_active_id", 32'(active_id), 32'h0);
        repeat (3) @(negedge clk_div_in);
        io_reset = 1'b0;
        mark = tr_w.size();
        wait_link(40, "reboot_link");
        repeat (3) @(posedge clk_div_in);
        check_boot(mark, "reboot");
        chk("reboot_no_ready", 32'(count_ready(mark, 1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
